switch_debounce: RTL

//  Synchronises and debounces the board's navigation and user switches (5 nav + 8 user = 13 bits)

---
 rtl/switch_debounce_pkg.sv | 19 +
 rtl/switch_debounce_if.sv | 21 ++
 rtl/switch_debounce_bit.sv | 94 +++++++++
 rtl/switch_debounce.sv | 79 +++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
//   NavSwWidth / UserSwWidth : board switch counts (5 nav + 8 user)
//   SwWidth                  : total debounced bits
//   DebounceTickCycles       : clk cycles per sample tick (1 ms at 30 MHz)
//   DebounceStableTicks      : ticks a new level must persist before it is accepted
package switch_debounce_pkg;

  localparam int unsigned NavSwWidth          = 5;
  localparam int unsigned UserSwWidth         = 8;
  localparam int unsigned SwWidth             = NavSwWidth + UserSwWidth;
  localparam int unsigned DebounceTickCycles  = 30_000;
  localparam int unsigned DebounceStableTicks = 5;

  // Width of a counter that must hold values 0..stable_ticks.
  function automatic int unsigned cnt_width(input int unsigned stable_ticks);
    return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch bundle between the raw pins and the debounced consumer.
//   sw_raw  : raw switch pins, asynchronous to the system clock
//   sw      : debounced level, 1 = pressed
//   rise    : one-cycle pulse per bit on press
//   fall    : one-cycle pulse per bit on release
//   changed : one-cycle pulse, OR of all rise/fall bits
// master drives the pins and observes results; slave is the debouncer.
interface switch_debounce_if
  import switch_debounce_pkg::*;
#(
  parameter int unsigned Width = SwWidth
);
  logic [Width-1:0] sw_raw;
  logic [Width-1:0] sw;
  logic [Width-1:0] rise;
  logic [Width-1:0] fall;
  logic             changed;

  modport master (output sw_raw, input sw, rise, fall, changed);
  modport slave  (input sw_raw, output sw, rise, fall, changed);
endinterface

// File: rtl/switch_debounce_bit.sv
// Debounce for a single switch bit.
//   clk_i     : system clock
//   rst_i     : asynchronous active-high reset
//   sw_raw_i  : raw pin, asynchronous
//   tick_i    : shared sample tick from the parent prescaler
//   level_o   : debounced level, 1 = pressed (registered)
//   rise_o    : one-cycle press pulse (registered)
//   fall_o    : one-cycle release pulse (registered)
//   event_d_o : next-state of rise|fall, lets the parent register changed in step
module switch_debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter bit          ActiveLow   = 1'b1,
  parameter int unsigned StableTicks = DebounceStableTicks
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic event_d_o
);

  localparam int unsigned CntW = cnt_width(StableTicks);
  localparam logic [CntW-1:0] CntLast = CntW'(StableTicks - 1);

  logic            sync1_q, sync2_q;
  logic            s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Synchroniser resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= ActiveLow;
      sync2_q <= ActiveLow;
    end else begin
      sync1_q <= sw_raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q ^ ActiveLow;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == level_q) begin
      // Any return to the accepted level restarts the stability window.
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CntLast) begin
        level_d = ~level_q;
        cnt_d   = '0;
        rise_d  = ~level_q;
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign event_d_o = rise_d | fall_d;

  edge_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0({rise_q, fall_q}));

  level_change_has_edge_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (level_q != $past(level_q)) |-> (rise_q | fall_q));

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces the board switches ahead of the GPIO input.
//   clk_i : system clock
//   rst_i : asynchronous active-high reset
//   bus   : slave side of switch_debounce_if
//           sw_raw in; sw, rise, fall, changed out (all outputs registered)
// A free-running prescaler produces the shared sample tick; each bit is debounced
// independently by switch_debounce_bit.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned Width       = SwWidth,
  parameter bit          ActiveLow   = 1'b1,
  parameter int unsigned TickCycles  = DebounceTickCycles,
  parameter int unsigned StableTicks = DebounceStableTicks
) (
  input logic              clk_i,
  input logic              rst_i,
  switch_debounce_if.slave bus
);

  localparam int unsigned PreW = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TickCycles - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic             tick;
  logic [Width-1:0] level, rise, fall, event_d;
  logic             changed_q, changed_d;

  // With TickCycles == 1 the counter stays at 0 and ticks every cycle.
  assign tick = (pre_q == PreLast);

  always_comb begin
    pre_d = pre_q + PreW'(1);
    if (tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < Width; i++) begin : g_bit
    switch_debounce_bit #(
      .ActiveLow  (ActiveLow),
      .StableTicks(StableTicks)
    ) u_bit (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .sw_raw_i (bus.sw_raw[i]),
      .tick_i   (tick),
      .level_o  (level[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i]),
      .event_d_o(event_d[i])
    );
  end

  // Built from next-state so it lands in the same cycle as the rise/fall bits.
  assign changed_d = |event_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign bus.sw      = level;
  assign bus.rise    = rise;
  assign bus.fall    = fall;
  assign bus.changed = changed_q;

endmodule
